// File: rtl/byte_ram_responder_pkg.sv
// Shared defines for the byte RAM responder: default geometry, IO register offsets
// and the access decoder used by the top level.
package byte_ram_responder_pkg;

    localparam int          RAM_AW_DEF     = 17;
    localparam int          FIFO_DEPTH_DEF = 8;
    localparam logic [31:0] IO_BASE_DEF    = 32'h0003_0000;
    localparam logic [31:0] IO_TX_OFF      = 32'h0000_0000;
    localparam logic [31:0] IO_STATUS_OFF  = 32'h0000_0004;

    typedef enum logic [2:0] {
        ACC_NONE,
        ACC_RAM_RD,
        ACC_RAM_WR,
        ACC_IO_TX,
        ACC_IO_STATUS,
        ACC_IO_RD_ZERO
    } acc_e;

    // bits [17:16]==2'b11 select IO; everything else is RAM (aliased by index width)
    function automatic acc_e acc_decode(input logic [31:0] a, input logic wr,
                                        input logic [31:0] base);
        if (a[17:16] != 2'b11) return wr ? ACC_RAM_WR : ACC_RAM_RD;
        if (wr)                return (a == base + IO_TX_OFF) ? ACC_IO_TX : ACC_NONE;
        return (a == base + IO_STATUS_OFF) ? ACC_IO_STATUS : ACC_IO_RD_ZERO;
    endfunction

endpackage

// File: rtl/io_out_fifo.sv
// Byte FIFO for the IO output channel; extra pointer MSB distinguishes full from empty.
module io_out_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] PTR_MSB = {1'b1, {(PW-1){1'b0}}};

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    mem [DEPTH];
    logic          do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr ^ rd_ptr) == PTR_MSB);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Forced to zero when empty so the output is defined straight out of reset
    assign head    = empty ? 8'h00 : mem[rd_ptr[PW-2:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-2:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/byte_ram_responder.sv
// Single-port byte RAM responder with a memory-mapped IO transmit FIFO and status register.
// The initiator is stalled (rdy_out low) whenever the FIFO is full.
module byte_ram_responder
    import byte_ram_responder_pkg::*;
#(
    parameter int          RAM_AW     = RAM_AW_DEF,
    parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter logic [31:0] IO_BASE    = IO_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_din,
    input  logic        mem_wr,
    output logic [7:0]  mem_dout,
    output logic        rdy_out,
    output logic [7:0]  io_data,
    output logic        io_valid,
    input  logic        io_ready
);
    logic              full, empty;
    acc_e              acc;
    logic [RAM_AW-1:0] idx;
    logic [7:0]        ram [0:(1 << RAM_AW) - 1];

    assign rdy_out  = !full;
    assign io_valid = !empty;
    assign idx      = mem_a[RAM_AW-1:0];
    // Nothing is sampled while stalled, so a stalled access has no side effect
    assign acc      = rdy_out ? acc_decode(mem_a, mem_wr, IO_BASE) : ACC_NONE;

    always_ff @(posedge clk) begin
        if (acc == ACC_RAM_WR) ram[idx] <= mem_din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_dout <= 8'h00;
        end else begin
            case (acc)
                ACC_RAM_RD:     mem_dout <= ram[idx];
                ACC_IO_STATUS:  mem_dout <= {6'b0, full, empty};
                ACC_IO_RD_ZERO: mem_dout <= 8'h00;
                default:        mem_dout <= mem_dout;
            endcase
        end
    end

    io_out_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (acc == ACC_IO_TX),
        .din   (mem_din),
        .pop   (io_valid && io_ready),
        .full  (full),
        .empty (empty),
        .head  (io_data)
    );

endmodule
